// File: rtl/clock_ce_gen.sv
// Clock-enable generator: one-hot phase strobes plus CH runtime-programmable fractional (NCO) clock-enables.
// Optional square-clock outputs per channel are built when CLOCK_SQUARE_OUT_EN is defined.
module clock_ce_gen #(
    parameter int unsigned PHASES  = 4,
    parameter int unsigned CH      = 4,
    parameter int unsigned ACC_W   = 12,
    parameter int unsigned DEF_NUM = 1,
    parameter int unsigned DEF_DEN = 8,
    localparam int unsigned PH_W   = (PHASES > 1) ? $clog2(PHASES) : 1,
    localparam int unsigned SEL_W  = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    output logic [PHASES-1:0] ph,
    output logic [PH_W-1:0]   ph_idx,
    input  logic              cfg_we,
    input  logic [SEL_W-1:0]  cfg_sel,
    input  logic [ACC_W-1:0]  cfg_num,
    input  logic [ACC_W-1:0]  cfg_den,
    output logic [CH-1:0]     ce
`ifdef CLOCK_SQUARE_OUT_EN
    ,
    output logic [CH-1:0]     clk_sq
`endif
);

    logic [PH_W-1:0]   cnt_q, cnt_d;
    logic [PHASES-1:0] ph_q, ph_d;
    logic [PH_W-1:0]   idx_q, idx_d;

    logic [ACC_W-1:0]  num_q [CH];
    logic [ACC_W-1:0]  num_d [CH];
    logic [ACC_W-1:0]  den_q [CH];
    logic [ACC_W-1:0]  den_d [CH];
    logic [ACC_W-1:0]  acc_q [CH];
    logic [ACC_W-1:0]  acc_d [CH];
    logic [ACC_W:0]    sum_c [CH];
    logic [CH-1:0]     ce_q, ce_d;
    logic [CH-1:0]     wr_c;
`ifdef CLOCK_SQUARE_OUT_EN
    logic [CH-1:0]     sq_q, sq_d;
`endif

    // Phase counter wraps naturally since PHASES is a power of two.
    always_comb begin
        cnt_d = cnt_q + PH_W'(1);
        ph_d  = PHASES'(1) << cnt_q;
        idx_d = cnt_q;
    end

    // Per-channel accumulator; a write on the same edge overrides any crossing.
    always_comb begin
        ce_d = '0;
        wr_c = '0;
        for (int n = 0; n < CH; n++) begin
            num_d[n] = num_q[n];
            den_d[n] = den_q[n];
            acc_d[n] = '0;
            sum_c[n] = {1'b0, acc_q[n]} + {1'b0, num_q[n]};
            wr_c[n]  = cfg_we && (32'(cfg_sel) == 32'(n));
            if (wr_c[n]) begin
                num_d[n] = cfg_num;
                den_d[n] = cfg_den;
            end else if (den_q[n] == '0) begin
                acc_d[n] = '0;
            end else if (sum_c[n] >= {1'b0, den_q[n]}) begin
                acc_d[n] = ACC_W'(sum_c[n] - {1'b0, den_q[n]});
                ce_d[n]  = 1'b1;
            end else begin
                acc_d[n] = ACC_W'(sum_c[n]);
            end
        end
    end

`ifdef CLOCK_SQUARE_OUT_EN
    // Square clock flips on every ce pulse; a write restarts it low.
    always_comb begin
        sq_d = '0;
        for (int n = 0; n < CH; n++) begin
            sq_d[n] = wr_c[n] ? 1'b0 : (sq_q[n] ^ ce_d[n]);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            ph_q  <= '0;
            idx_q <= '0;
            ce_q  <= '0;
`ifdef CLOCK_SQUARE_OUT_EN
            sq_q  <= '0;
`endif
            for (int n = 0; n < CH; n++) begin
                num_q[n] <= ACC_W'(DEF_NUM);
                den_q[n] <= ACC_W'(DEF_DEN);
                acc_q[n] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            ph_q  <= ph_d;
            idx_q <= idx_d;
            ce_q  <= ce_d;
`ifdef CLOCK_SQUARE_OUT_EN
            sq_q  <= sq_d;
`endif
            for (int n = 0; n < CH; n++) begin
                num_q[n] <= num_d[n];
                den_q[n] <= den_d[n];
                acc_q[n] <= acc_d[n];
            end
        end
    end

    assign ph     = ph_q;
    assign ph_idx = idx_q;
    assign ce     = ce_q;
`ifdef CLOCK_SQUARE_OUT_EN
    assign clk_sq = sq_q;
`endif

endmodule

// File: tb/tb_clock_ce_gen.sv
// Scoreboard bench for clock_ce_gen: the reference model derives ce from floor(t*num/den) steps.
`timescale 1ns/1ps
module tb_clock_ce_gen;

    localparam int unsigned PHASES  = 4;
    localparam int unsigned CH      = 4;
    localparam int unsigned ACC_W   = 12;
    localparam int unsigned DEF_NUM = 1;
    localparam int unsigned DEF_DEN = 8;
    localparam int unsigned PH_W    = 2;
    localparam int unsigned SEL_W   = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cfg_we = 1'b0;
    logic [SEL_W-1:0]  cfg_sel = '0;
    logic [ACC_W-1:0]  cfg_num = '0;
    logic [ACC_W-1:0]  cfg_den = '0;
    logic [PHASES-1:0] ph;
    logic [PH_W-1:0]   ph_idx;
    logic [CH-1:0]     ce;
`ifdef CLOCK_SQUARE_OUT_EN
    logic [CH-1:0]     clk_sq;
`endif

    clock_ce_gen #(
        .PHASES(PHASES), .CH(CH), .ACC_W(ACC_W), .DEF_NUM(DEF_NUM), .DEF_DEN(DEF_DEN)
    ) dut (
        .clk(clk), .rst(rst), .ph(ph), .ph_idx(ph_idx),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_num(cfg_num), .cfg_den(cfg_den),
        .ce(ce)
`ifdef CLOCK_SQUARE_OUT_EN
        , .clk_sq(clk_sq)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PHASES-1:0] ph;
        logic [PH_W-1:0]   idx;
        logic [CH-1:0]     ce;
        logic [CH-1:0]     sq;
    } exp_t;

    exp_t            q[$];
    int              checks = 0;
    int              errors = 0;
    bit              started = 1'b0;
    bit              count_en = 1'b0;
    int              ce1_cnt = 0;

    // Reference model: pulses since (re)configuration = floor(t*num/den).
    longint unsigned m_num [CH];
    longint unsigned m_den [CH];
    longint unsigned m_t   [CH];
    bit              m_sq  [CH];
    int              m_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic cycle(input bit r, input bit we, input int sel,
                         input int unsigned num, input int unsigned den);
        exp_t e;
        @(negedge clk);
        rst     = r;
        cfg_we  = we;
        cfg_sel = SEL_W'(sel);
        cfg_num = ACC_W'(num);
        cfg_den = ACC_W'(den);
        e.ce = '0;
        e.sq = '0;
        if (r) begin
            m_cnt = 0;
            e.ph  = '0;
            e.idx = '0;
            for (int n = 0; n < CH; n++) begin
                m_num[n] = DEF_NUM;
                m_den[n] = DEF_DEN;
                m_t[n]   = 0;
                m_sq[n]  = 1'b0;
            end
        end else begin
            e.ph  = PHASES'(1) << m_cnt;
            e.idx = PH_W'(m_cnt);
            m_cnt = (m_cnt + 1) % PHASES;
            for (int n = 0; n < CH; n++) begin
                if (we && sel == n) begin
                    m_num[n] = longint'(num % (1 << ACC_W));
                    m_den[n] = longint'(den % (1 << ACC_W));
                    m_t[n]   = 0;
                    m_sq[n]  = 1'b0;
                end else begin
                    m_t[n]++;
                    if (m_den[n] != 0 &&
                        (m_t[n] * m_num[n] / m_den[n]) != ((m_t[n] - 1) * m_num[n] / m_den[n])) begin
                        e.ce[n] = 1'b1;
                        m_sq[n] = !m_sq[n];
                    end
                end
                e.sq[n] = m_sq[n];
            end
        end
        q.push_back(e);
        started = 1'b1;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) cycle(1'b0, 1'b0, 0, 0, 0);
    endtask

    // Monitor: one expected entry per clock edge once stimulus has begun.
    initial begin
        exp_t e;
        wait (started);
        forever begin
            @(posedge clk);
            #1;
            if (count_en) ce1_cnt += int'(ce[1]);
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty at %0t: got no expected entry, required one", $time);
            end else begin
                e = q.pop_front();
                chk("ph", 32'(ph), 32'(e.ph));
                chk("ph_idx", 32'(ph_idx), 32'(e.idx));
                chk("ce", 32'(ce), 32'(e.ce));
`ifdef CLOCK_SQUARE_OUT_EN
                chk("clk_sq", 32'(clk_sq), 32'(e.sq));
`endif
            end
        end
    end

    initial begin
        int guard;
        cycle(1'b1, 1'b0, 0, 0, 0);
        cycle(1'b1, 1'b0, 0, 0, 0);
        // Defaults and phase rotation.
        idle(40);
        // 3/8 channel: 300 pulses in 800 steps.
        cycle(1'b0, 1'b1, 1, 3, 8);
        count_en = 1'b1;
        idle(800);
        @(posedge clk);
        #2;
        count_en = 1'b0;
        chk("ce1_count_800", 32'(ce1_cnt), 32'd300);
        // 2/7 then 5/5 (constant high).
        cycle(1'b0, 1'b1, 2, 2, 7);
        idle(30);
        cycle(1'b0, 1'b1, 2, 5, 5);
        idle(20);
        // Channel off, then reprogram on a ch0 crossing edge.
        cycle(1'b0, 1'b1, 3, 7, 0);
        idle(20);
        guard = 0;
        while (guard < 20 &&
               ((m_t[0] + 1) * m_num[0] / m_den[0]) == (m_t[0] * m_num[0] / m_den[0])) begin
            idle(1);
            guard++;
        end
        chk("ch0_cross_found", 32'(guard < 20), 32'd1);
        cycle(1'b0, 1'b1, 3, 1, 2);
        idle(20);
        // Mid-run reset, then reset colliding with a write.
        cycle(1'b1, 1'b0, 0, 0, 0);
        idle(30);
        cycle(1'b1, 1'b1, 2, 5, 5);
        idle(30);
        // Randomized writes and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            bit          r;
            bit          we;
            int unsigned num;
            int unsigned den;
            r  = ($urandom_range(0, 299) == 0);
            we = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 3) == 0) begin
                num = $urandom_range(0, 4095);
                den = $urandom_range(0, 4095);
            end else begin
                num = $urandom_range(0, 16);
                den = $urandom_range(0, 16);
            end
            cycle(r, we, int'($urandom_range(0, CH - 1)), num, den);
        end
        idle(2);
        @(posedge clk);
        #2;
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
